// File: rtl/mips_pkg.sv
// Shared MIPS definitions: HI/LO unit op codes and FSM states.
// Includes the operand magnitude helper used when a multiply or divide is accepted.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  function automatic logic [31:0] mag32(
    input logic [31:0] x,
    input logic        sgn
  );
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, with sign correction applied in a final fix-up cycle.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  md_state_e     state_q;
  op_e           op_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   acc_q;
  logic [31:0]   opnd_q;
  logic          negq_q;
  logic          negr_q;
  logic          dz_q;

  op_e         op_in;
  logic        sgn_in;
  logic        div_in;
  logic        is_mul;
  logic [32:0] madd;
  logic [33:0] dsub;
  logic [63:0] step_d;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign op_in  = op_e'(op);
  assign sgn_in = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign div_in = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign is_mul = (op_q == OP_MULT) || (op_q == OP_MULTU);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    madd   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    dsub   = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};
    step_d = acc_q;
    if (is_mul)
      step_d = {madd, acc_q[31:1]};
    else if (!dsub[33])
      step_d = {dsub[31:0], acc_q[30:0], 1'b1};
    else
      step_d = {acc_q[62:0], 1'b0};
  end

  always_comb begin
    prod_fix = negq_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = negq_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = negr_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q   <= op_in;
            cnt_q  <= '0;
            acc_q  <= {32'd0, mag32(a, sgn_in)};
            opnd_q <= mag32(b, sgn_in);
            negq_q <= sgn_in && (a[31] ^ b[31]);
            negr_q <= sgn_in && a[31];
            dz_q   <= div_in && (b == 32'd0);
            busy   <= 1'b1;
            // divide by zero skips iteration and finishes on the next edge
            state_q <= (div_in && (b == 32'd0)) ? FIX : RUN;
          end
        end
        RUN: begin
          acc_q <= step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= dz_q;
          state_q  <= IDLE;
          if (!dz_q) begin
            if (is_mul) begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs change 1ns after the rising edge; outputs are sampled at that point.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int lat;
  int bcyc;

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Drive start for one edge, then count cycles until done (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, output int l, output int bc);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    l = 0; bc = 0;
    while (!done && l < 100) begin
      if (busy) bc++;
      tick();
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
    chk("multu_lat", 64'(lat), 64'd33);
    chk("multu_busy", 64'(bcyc), 64'd33);
    chk("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    chk("multu_dz", 64'(div_zero), 64'd0);
    tick();
    chk("done_pulse", 64'(done), 64'd0);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bcyc);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcyc);
    chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(2'b11, 32'd100, 32'd7, lat, bcyc);
    chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});

    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, bcyc);
    chk("div_7_m2", {hi, lo}, {32'd1, 32'hFFFF_FFFD});

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
    chk("div_wrap", {hi, lo}, {32'd0, 32'h8000_0000});
    chk("div_wrap_dz", 64'(div_zero), 64'd0);

    hi_we = 1'b1; wdata = 32'h11;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    tick();
    lo_we = 1'b0;
    run_op(2'b10, 32'd5, 32'd0, lat, bcyc);
    chk("dz_lat", 64'(lat), 64'd1);
    chk("dz_busy", 64'(bcyc), 64'd1);
    chk("dz_flag", 64'(div_zero), 64'd1);
    chk("dz_hilo", {hi, lo}, {32'h11, 32'h22});
    tick();
    chk("dz_pulse", 64'({done, div_zero}), 64'd0);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("move_both", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // move and start in the same idle cycle: move lands, result overwrites
    hi_we = 1'b1; wdata = 32'hDEAD;
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    hi_we = 1'b0; start = 1'b0;
    chk("same_cyc_mv", 64'(hi), 64'hDEAD);
    lat = 0;
    while (!done && lat < 100) begin tick(); lat++; end
    chk("same_cyc_res", {hi, lo}, {32'd0, 32'd15});

    // second start and mthi during a multiply are ignored
    op = 2'b01; a = 32'h1_0000; b = 32'h1_0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1;
    hi_we = 1'b1; wdata = 32'h5555;
    tick();
    start = 1'b0; hi_we = 1'b0;
    chk("busy_mthi", 64'(hi), 64'd0);
    lat = 6;
    while (!done && lat < 100) begin tick(); lat++; end
    chk("busy_lat", 64'(lat), 64'd33);
    chk("busy_res", {hi, lo}, {32'd1, 32'd0});
    tick();
    chk("no_queue", 64'({busy, done}), 64'd0);

    // reset in the middle of a divide aborts it
    op = 2'b11; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", {29'd0, busy, done, div_zero, hi}, 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    bcyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) bcyc++;
      tick();
    end
    chk("abort_nodone", 64'(bcyc), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
